// File: rtl/fpu_pkg.sv
// Shared FPU definitions: float field widths, exponent bias/limits,
// one-hot status codes and the int_to_fpu state encoding.
package fpu_pkg;
  localparam int EXP_W    = 6;
  localparam int FRAC_W   = 25;
  localparam int EXP_BIAS = 31;
  localparam int EXP_MAX  = 63;

  localparam logic [3:0] ST_EXACT     = 4'b0001;
  localparam logic [3:0] ST_INEXACT   = 4'b0010;
  localparam logic [3:0] ST_OVERFLOW  = 4'b0100;
  localparam logic [3:0] ST_UNDERFLOW = 4'b1000;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ABS   = 2'd1,
    S_NORM  = 2'd2,
    S_ROUND = 2'd3
  } i2f_state_t;
endpackage

// File: rtl/lzc32.sv
// 32-bit leading-zero counter.
//   din : operand
//   cnt : number of leading zeros (32 when din == 0)
module lzc32 (
  input  logic [31:0] din,
  output logic [5:0]  cnt
);
  // Ascending scan: the highest set bit is the last to write cnt.
  always_comb begin
    cnt = 6'd32;
    for (int i = 0; i < 32; i++)
      if (din[i]) cnt = 6'(31 - i);
  end
endmodule

// File: rtl/int_to_fpu.sv
// Integer to float encoder: converts a signed 32-bit integer into
// {sign, exp[5:0], frac[24:0]} (hidden 1, bias EXP_BIAS) with the FPU
// one-hot status code. Multi-cycle FSM IDLE -> ABS -> NORM -> ROUND.
//   clock100KHz : clock
//   reset       : synchronous, active-high
//   int_in      : operand, captured when start is accepted in IDLE
//   start       : launch a conversion (ignored while busy)
//   busy        : conversion in flight
//   done        : one-cycle pulse, data_out/status_out valid
//   data_out    : result, held until the next result
//   status_out  : 0001 exact, 0010 inexact, 0100 overflow, 1000 underflow
// Optional macro INT_TO_FPU_FAST_NORM_EN: single-cycle normalisation via
// a leading-zero counter instead of one shift per cycle.
module int_to_fpu #(
  parameter int EXP_BIAS = 31,
  parameter int INT_W    = 32
) (
  input  logic             clock100KHz,
  input  logic             reset,
  input  logic [INT_W-1:0] int_in,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [31:0]      data_out,
  output logic [3:0]       status_out
);
  import fpu_pkg::*;

  localparam logic [EXP_W-1:0] EXP_TOP = EXP_W'(EXP_BIAS + INT_W - 1);
  localparam logic [EXP_W:0]   EXP_OVF = (EXP_W+1)'(EXP_MAX);

  i2f_state_t state, state_nxt;

  logic [INT_W-1:0] op_q;
  logic [31:0]      mag_q;
  logic [EXP_W-1:0] exp_q;
  logic             sign_q;

  // Round half-up; a carry out of the fraction bumps the exponent and
  // leaves the low FRAC_W bits at zero.
  logic [FRAC_W:0]  frac_sum;
  logic [EXP_W:0]   exp_rnd;
  logic             inexact;

  always_comb begin
    frac_sum = {1'b0, mag_q[30:6]} + {{FRAC_W{1'b0}}, mag_q[5]};
    exp_rnd  = {1'b0, exp_q} + {{EXP_W{1'b0}}, frac_sum[FRAC_W]};
    inexact  = |mag_q[5:0];
  end

`ifdef INT_TO_FPU_FAST_NORM_EN
  logic [5:0] lz;
  lzc32 u_lzc (.din(mag_q), .cnt(lz));
`endif

  // State register
  always_ff @(posedge clock100KHz) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next state. A zero magnitude is retired from NORM so the zero result
  // lands one edge after ABS, like a k=0 normalisation step.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_ABS;
      S_ABS:   state_nxt = S_NORM;
`ifdef INT_TO_FPU_FAST_NORM_EN
      S_NORM:  state_nxt = (mag_q == '0) ? S_IDLE : S_ROUND;
`else
      S_NORM:  if (mag_q == '0)  state_nxt = S_IDLE;
               else if (mag_q[31]) state_nxt = S_ROUND;
`endif
      S_ROUND: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    busy = (state != S_IDLE);
  end

  // Datapath and registered results
  always_ff @(posedge clock100KHz) begin
    if (reset) begin
      op_q       <= '0;
      mag_q      <= '0;
      exp_q      <= '0;
      sign_q     <= 1'b0;
      done       <= 1'b0;
      data_out   <= '0;
      status_out <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: if (start) op_q <= int_in;
        S_ABS: begin
          sign_q <= op_q[INT_W-1];
          // 0x80000000 negates to itself, which is the correct magnitude.
          mag_q  <= op_q[INT_W-1] ? 32'(-op_q) : 32'(op_q);
          exp_q  <= EXP_TOP;
        end
        S_NORM: begin
          if (mag_q == '0) begin
            data_out   <= '0;
            status_out <= ST_EXACT;
            done       <= 1'b1;
          end else begin
`ifdef INT_TO_FPU_FAST_NORM_EN
            mag_q <= mag_q << lz;
            exp_q <= exp_q - lz;
`else
            if (!mag_q[31]) begin
              mag_q <= mag_q << 1;
              exp_q <= exp_q - 1'b1;
            end
`endif
          end
        end
        S_ROUND: begin
          if (exp_rnd >= EXP_OVF) begin
            data_out   <= '0;
            status_out <= ST_OVERFLOW;
          end else if (exp_rnd == '0) begin
            data_out   <= '0;
            status_out <= ST_UNDERFLOW;
          end else begin
            data_out   <= {sign_q, exp_rnd[EXP_W-1:0], frac_sum[FRAC_W-1:0]};
            status_out <= inexact ? ST_INEXACT : ST_EXACT;
          end
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule
